// File: rtl/mips_alu_pkg.sv
// Shared ALU function codes and divide-sequencer state encoding.
package mips_alu_pkg;

  localparam logic [5:0] F_divu = 6'd27;
  localparam logic [5:0] F_mfhi = 6'b010000;
  localparam logic [5:0] F_mflo = 6'b010010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } divu_state_t;

endpackage

// File: rtl/divu_step.sv
// One restoring-division iteration: shift {A,Q} left by one, then subtract D
// from A when it fits and shift a 1 into the quotient.
// The compare uses WIDTH+1 bits because the shifted partial remainder can
// exceed 2^WIDTH-1 when the divisor is above 2^(WIDTH-1).
module divu_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0]   a_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  assign a_sh = {a_in, q_in[WIDTH-1]};
  assign ge   = (a_sh >= {1'b0, d});
  // When ge holds the true difference is below d, so the low WIDTH bits are exact.
  assign diff = a_sh[WIDTH-1:0] - d;

  assign a_out = ge ? diff : a_sh[WIDTH-1:0];
  assign q_out = {q_in[WIDTH-2:0], ge};

endmodule

// File: rtl/divu_hilo_seq.sv
// EX-stage unsigned divide sequencer and HI/LO register owner.
// Quotient lands in LO, remainder in HI; the pipeline is stalled while a
// divide is in flight and an instruction needs HI/LO or the divider.
//
// Optional build macro DIVU_FAST_ZERO_EN: a divide whose quotient is trivially
// zero (dividend < divisor) or whose divisor is zero bypasses CALC and
// completes on the accepting edge with identical HI/LO results.
//
// state | meaning
// IDLE  | no divide in flight
// CALC  | iterating, one quotient bit per cycle, cnt = bits remaining
// DONE  | HI/LO just updated; may accept a new divu this cycle
module divu_hilo_seq
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       alu_op,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic             dbz
);

  divu_state_t state, state_nxt;

  logic [WIDTH-1:0] a_reg, q_reg, d_reg;
  logic [WIDTH-1:0] a_nxt, q_nxt;
  logic [CNT_W-1:0] cnt;
  logic             start, rd, accept, last, fast;

  assign start  = ex_valid && (alu_op == F_divu);
  assign rd     = ex_valid && ((alu_op == F_mfhi) || (alu_op == F_mflo));
  assign accept = start && (state != CALC);
  assign last   = (state == CALC) && (cnt == CNT_W'(1));

`ifdef DIVU_FAST_ZERO_EN
  assign fast = (dividend < divisor) || (divisor == '0);
`else
  assign fast = 1'b0;
`endif

  divu_step #(.WIDTH(WIDTH)) u_step (
    .a_in  (a_reg),
    .q_in  (q_reg),
    .d     (d_reg),
    .a_out (a_nxt),
    .q_out (q_nxt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; DONE behaves like IDLE for a new start.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = fast ? DONE : CALC;
        else       state_nxt = IDLE;
      end
      CALC:    if (last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs; stall only exists while the divider is iterating.
  always_comb begin
    busy  = (state != IDLE);
    done  = (state == DONE);
    stall = (state == CALC) && (start || rd);
  end

  // Divider datapath, down-counter and HI/LO update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg <= '0;
      q_reg <= '0;
      d_reg <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      dbz   <= 1'b0;
    end else if (accept) begin
      a_reg <= '0;
      q_reg <= dividend;
      d_reg <= divisor;
      cnt   <= CNT_W'(WIDTH);
      dbz   <= (divisor == '0);
      if (fast) begin
        cnt <= '0;
        hi  <= dividend;
        lo  <= (divisor == '0) ? '1 : '0;
      end
    end else if (state == CALC) begin
      a_reg <= a_nxt;
      q_reg <= q_nxt;
      cnt   <= cnt - CNT_W'(1);
      if (last) begin
        hi <= a_nxt;
        lo <= q_nxt;
      end
    end
  end

endmodule

// File: tb/tb_divu_hilo_seq.sv
// Directed bench for divu_hilo_seq (WIDTH=32).
module tb_divu_hilo_seq;

  localparam int W = 32;
  localparam logic [5:0] OP_DIVU = 6'd27;
  localparam logic [5:0] OP_MFHI = 6'b010000;
  localparam logic [5:0] OP_ADD  = 6'd32;

  logic         clk;
  logic         rst;
  logic [5:0]   alu_op;
  logic         ex_valid;
  logic [W-1:0] dividend, divisor;
  logic [W-1:0] hi, lo;
  logic         busy, done, stall, dbz;

  int checks = 0;
  int errors = 0;
  int lat, busy_n, n;

  divu_hilo_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .alu_op   (alu_op),
    .ex_valid (ex_valid),
    .dividend (dividend),
    .divisor  (divisor),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .stall    (stall),
    .dbz      (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    alu_op   = op;
    ex_valid = 1'b1;
    dividend = a;
    divisor  = b;
  endtask

  task automatic idle_in();
    alu_op   = 6'd0;
    ex_valid = 1'b0;
  endtask

  // Count falling edges until done is seen; lat=0 means the bound expired.
  task automatic wait_done(output int lat_o, output int busy_o);
    lat_o  = 0;
    busy_o = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk); #1;
      if (busy) busy_o++;
      if (done) begin
        lat_o = k;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    idle_in();
    dividend = '0;
    divisor  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_dbz", dbz, 1'b0);
    rst = 1'b1;

    // divu opcode without ex_valid must not start
    @(negedge clk);
    alu_op = OP_DIVU; dividend = 32'd5; divisor = 32'd1;
    @(negedge clk); #1;
    check("bubble_nostart", busy, 1'b0);
    idle_in();

    // 1. 100/7 with latency and busy-length checks
    @(negedge clk);
    issue(OP_DIVU, 32'd100, 32'd7);
    #1 check("t1_idle_nostall", stall, 1'b0);
    @(posedge clk); #1 idle_in();
    wait_done(lat, busy_n);
    check("t1_latency", lat, 33);
    check("t1_busy_cycles", busy_n, 33);
    check("t1_lo", lo, 32'd14);
    check("t1_hi", hi, 32'd2);
    @(negedge clk); #1;
    check("t1_done_pulse", done, 1'b0);
    check("t1_idle", busy, 1'b0);

    // 2. wide compare path; HI/LO hold old values mid-divide
    @(negedge clk);
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0000);
    @(posedge clk); #1 idle_in();
    repeat (16) @(negedge clk);
    #1;
    check("t2_lo_hold", lo, 32'd14);
    check("t2_hi_hold", hi, 32'd2);
    wait_done(lat, busy_n);
    check("t2_done_seen", (lat != 0), 1'b1);
    check("t2_lo", lo, 32'd1);
    check("t2_hi", hi, 32'h7FFF_FFFF);
    check("t2_dbz", dbz, 1'b0);

    // 3. divide by zero
    @(negedge clk);
    issue(OP_DIVU, 32'h1234, 32'h0);
    @(posedge clk); #1 idle_in();
    wait_done(lat, busy_n);
    check("t3_done_seen", (lat != 0), 1'b1);
    check("t3_lo", lo, 32'hFFFF_FFFF);
    check("t3_hi", hi, 32'h1234);
    check("t3_dbz", dbz, 1'b1);
    repeat (3) @(negedge clk);
    #1 check("t3_dbz_sticky", dbz, 1'b1);

    // 4. add overlaps the divide, mfhi stalls until DONE
    @(negedge clk);
    issue(OP_DIVU, 32'd1003, 32'd10);
    @(posedge clk); #1 issue(OP_ADD, 32'd1, 32'd2);
    @(negedge clk); #1 check("t4_add_nostall", stall, 1'b0);
    check("t4_add_busy", busy, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1 issue(OP_MFHI, 32'd0, 32'd0);
    @(negedge clk); #1 check("t4_mfhi_stall", stall, 1'b1);
    n = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk); #1;
      if (!stall) break;
      n++;
    end
    check("t4_stall_bounded", (n < 60), 1'b1);
    check("t4_release_in_done", done, 1'b1);
    check("t4_mfhi_hi", hi, 32'd3);
    check("t4_lo", lo, 32'd100);
    check("t4_dbz_clear", dbz, 1'b0);
    @(posedge clk); #1 idle_in();

    // 5. back-to-back divu: second waits, accepted in DONE
    @(negedge clk);
    issue(OP_DIVU, 32'd50, 32'd6);
    @(posedge clk); #1 issue(OP_DIVU, 32'd77, 32'd5);
    @(negedge clk); #1 check("t5_second_stall", stall, 1'b1);
    wait_done(lat, busy_n);
    check("t5_first_latency", lat, 32);
    check("t5_done_nostall", stall, 1'b0);
    check("t5_first_lo", lo, 32'd8);
    check("t5_first_hi", hi, 32'd2);
    @(posedge clk); #1 idle_in();
    wait_done(lat, busy_n);
    check("t5_second_latency", lat, 33);
    check("t5_second_lo", lo, 32'd15);
    check("t5_second_hi", hi, 32'd2);

    // 6. async reset mid-CALC
    @(negedge clk);
    issue(OP_DIVU, 32'hFFFF, 32'd3);
    @(posedge clk); #1 idle_in();
    repeat (22) @(negedge clk);
    issue(OP_MFHI, 32'd0, 32'd0);
    #1 check("t6_pre_stall", stall, 1'b1);
    #1 rst = 1'b0;
    #1;
    check("t6_stall", stall, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_hi", hi, 32'h0);
    check("t6_lo", lo, 32'h0);
    idle_in();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(OP_DIVU, 32'd9, 32'd3);
    @(posedge clk); #1 idle_in();
    wait_done(lat, busy_n);
    check("t6_done_seen", (lat != 0), 1'b1);
    check("t6_lo", lo, 32'd3);
    check("t6_hi", hi, 32'd0);

    // 5/9: trivial quotient, fast path when enabled
    @(negedge clk);
    issue(OP_DIVU, 32'd5, 32'd9);
    @(posedge clk); #1 idle_in();
    wait_done(lat, busy_n);
`ifdef DIVU_FAST_ZERO_EN
    check("small_latency", lat, 1);
`else
    check("small_latency", lat, 33);
`endif
    check("small_lo", lo, 32'd0);
    check("small_hi", hi, 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
